// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/squash generation, interrupt drain FSM
// with completion handshake, and a saturating stall-cycle counter.
package pipe_hazard_pkg;
  typedef enum logic [1:0] {
    PLUS_4     = 2'd0,
    BRANCH_TGT = 2'd1,
    JUMP_TGT   = 2'd2,
    TRAP_TGT   = 2'd3
  } pc_src_e;

  typedef struct packed {
    logic stall;
    logic squash;
  } stage_ctrl_t;
endpackage

module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH     = 5,
  parameter int BC_STAGE  = 2,
  parameter int EX_STAGE  = 2,
  parameter int MEM_STAGE = 3,
  parameter int CNT_W     = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mem_acc_stall_i,
  input  logic                    mem_read_stall_i,
  input  pc_src_e                 pc_src_i,
  input  logic                    csr_mret_i,
  input  logic                    csr_flush_i,
  input  logic                    load_use_stall_i,
  output logic                    flush_busy_o,
  output logic                    flush_done_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output stage_ctrl_t [DEPTH-1:0] stage_ctrl_ao
);

  if (!(BC_STAGE > 0 && BC_STAGE <= EX_STAGE && EX_STAGE < MEM_STAGE &&
        MEM_STAGE < DEPTH && CNT_W >= 1)) begin : g_bad_params
    $error("pipe_hazard_ctrl: illegal stage indices or counter width");
  end

  localparam int DCW = (EX_STAGE > 1) ? $clog2(EX_STAGE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

  flush_state_e   state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall;
  logic redirect;
  logic flush_rule;

  assign mem_stall = mem_acc_stall_i | mem_read_stall_i;
  assign redirect  = (pc_src_i != PLUS_4) | csr_mret_i;
  // Rule 4 is suppressed while reset is held so the controls reflect live inputs only.
  assign flush_rule = rst_ni & ((state_q == DRAIN) | ((state_q == IDLE) & csr_flush_i));

  always_comb begin
    stage_ctrl_ao = '0;
    if (mem_stall) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i <= MEM_STAGE) stage_ctrl_ao[i].stall = 1'b1;
      end
      stage_ctrl_ao[MEM_STAGE].squash = 1'b1;
    end else begin
      if (load_use_stall_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i <= EX_STAGE) stage_ctrl_ao[i].stall = 1'b1;
        end
        stage_ctrl_ao[EX_STAGE].squash = 1'b1;
      end else if (redirect) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i < BC_STAGE) stage_ctrl_ao[i].squash = 1'b1;
        end
      end
      if (flush_rule) begin
        stage_ctrl_ao[0].stall  = 1'b1;
        stage_ctrl_ao[0].squash = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Drain advances only on cycles where the pipeline actually moves.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE: begin
        if (csr_flush_i) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          if (drain_cnt_q == DCW'(EX_STAGE)) begin
            state_d     = DONE;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_busy_o = (state_q == DRAIN);
    flush_done_o = (state_q == DONE);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stage_ctrl_ao[0].stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default-width instance plus a 4-bit counter
// instance sharing the same stimulus.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_acc, mem_read, mret, flush, load_use;
  pc_src_e     pc_src;
  logic        busy, done, busy_s, done_s;
  logic [31:0] cnt;
  logic [3:0]  cnt_s;
  stage_ctrl_t [4:0] ctrl, ctrl_s;
  logic [4:0]  stall_v, squash_v;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .mem_acc_stall_i(mem_acc), .mem_read_stall_i(mem_read),
    .pc_src_i(pc_src), .csr_mret_i(mret), .csr_flush_i(flush), .load_use_stall_i(load_use),
    .flush_busy_o(busy), .flush_done_o(done), .stall_cnt_o(cnt), .stage_ctrl_ao(ctrl)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .mem_acc_stall_i(mem_acc), .mem_read_stall_i(mem_read),
    .pc_src_i(pc_src), .csr_mret_i(mret), .csr_flush_i(flush), .load_use_stall_i(load_use),
    .flush_busy_o(busy_s), .flush_done_o(done_s), .stall_cnt_o(cnt_s), .stage_ctrl_ao(ctrl_s)
  );

  always_comb begin
    stall_v  = '0;
    squash_v = '0;
    for (int i = 0; i < 5; i++) begin
      stall_v[i]  = ctrl[i].stall;
      squash_v[i] = ctrl[i].squash;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [4:0] st, input logic [4:0] sq);
    chk({tag, ".stall"}, {27'd0, stall_v}, {27'd0, st});
    chk({tag, ".squash"}, {27'd0, squash_v}, {27'd0, sq});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_acc = 1'b0; mem_read = 1'b0; mret = 1'b0;
    flush = 1'b0; load_use = 1'b0; pc_src = PLUS_4;

    // Reset state, and rule 1 live during reset
    @(negedge clk);
    chk_ctrl("rst_idle", 5'b00000, 5'b00000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    mem_read = 1'b1; flush = 1'b1;
    #1;
    chk_ctrl("rst_memstall", 5'b01111, 5'b01000);
    cyc();
    chk("rst_cnt_hold", cnt, 32'd0);
    chk("rst_busy_hold", {31'd0, busy}, 32'd0);
    mem_read = 1'b0; flush = 1'b0;
    rst_n = 1'b1;

    // Control redirect
    pc_src = BRANCH_TGT;
    @(negedge clk);
    chk_ctrl("branch", 5'b00000, 5'b00011);
    cyc();
    pc_src = PLUS_4; mret = 1'b1;
    @(negedge clk);
    chk_ctrl("mret", 5'b00000, 5'b00011);
    cyc();
    mret = 1'b0;
    @(negedge clk);
    chk("cnt_after_ctrl", cnt, 32'd0);

    // Load-use masks the redirect
    cyc();
    load_use = 1'b1; pc_src = JUMP_TGT;
    @(negedge clk);
    chk_ctrl("loaduse", 5'b00111, 5'b00100);
    cyc();
    load_use = 1'b0; pc_src = PLUS_4;
    @(negedge clk);
    chk("cnt_loaduse", cnt, 32'd1);

    // Memory stall masks load-use and mret for 3 cycles
    cyc();
    mem_read = 1'b1; load_use = 1'b1; mret = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_ctrl($sformatf("memstall%0d", k), 5'b01111, 5'b01000);
      cyc();
    end
    mem_read = 1'b0; load_use = 1'b0; mret = 1'b0;
    @(negedge clk);
    chk("cnt_memstall", cnt, 32'd4);
    chk_ctrl("memstall_rel", 5'b00000, 5'b00000);

    // Base interrupt drain, t0
    cyc();
    flush = 1'b1;
    @(negedge clk);
    chk_ctrl("drain_t0", 5'b00001, 5'b00001);
    chk("drain_t0_busy", {31'd0, busy}, 32'd0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk_ctrl("drain_t1", 5'b00001, 5'b00001);
    chk("drain_t1_busy", {31'd0, busy}, 32'd1);
    cyc();
    flush = 1'b1;
    @(negedge clk);
    chk_ctrl("drain_t2", 5'b00001, 5'b00001);
    chk("drain_t2_busy", {31'd0, busy}, 32'd1);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk_ctrl("drain_t3", 5'b00001, 5'b00001);
    chk("drain_t3_busy", {31'd0, busy}, 32'd1);
    chk("drain_t3_done", {31'd0, done}, 32'd0);
    cyc();
    @(negedge clk);
    chk("drain_t4_done", {31'd0, done}, 32'd1);
    chk("drain_t4_busy", {31'd0, busy}, 32'd0);
    chk_ctrl("drain_t4", 5'b00000, 5'b00000);
    cyc();
    @(negedge clk);
    chk("drain_t5_done", {31'd0, done}, 32'd0);
    chk("drain_t5_busy", {31'd0, busy}, 32'd0);
    chk("cnt_drain", cnt, 32'd8);

    // Drain extended by a memory miss at t0+2..t0+3
    cyc();
    flush = 1'b1;
    @(negedge clk);
    chk_ctrl("ext_t0", 5'b00001, 5'b00001);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("ext_t1_busy", {31'd0, busy}, 32'd1);
    cyc();
    mem_acc = 1'b1;
    @(negedge clk);
    chk_ctrl("ext_t2", 5'b01111, 5'b01000);
    chk("ext_t2_busy", {31'd0, busy}, 32'd1);
    cyc();
    @(negedge clk);
    chk_ctrl("ext_t3", 5'b01111, 5'b01000);
    cyc();
    mem_acc = 1'b0;
    @(negedge clk);
    chk_ctrl("ext_t4", 5'b00001, 5'b00001);
    chk("ext_t4_busy", {31'd0, busy}, 32'd1);
    cyc();
    @(negedge clk);
    chk("ext_t5_busy", {31'd0, busy}, 32'd1);
    chk("ext_t5_done", {31'd0, done}, 32'd0);
    cyc();
    @(negedge clk);
    chk("ext_t6_done", {31'd0, done}, 32'd1);
    chk("ext_t6_busy", {31'd0, busy}, 32'd0);
    cyc();
    @(negedge clk);
    chk("ext_t7_done", {31'd0, done}, 32'd0);
    chk("cnt_ext", cnt, 32'd14);
    chk("cnt_s_ext", {28'd0, cnt_s}, 32'd14);

    // Reset in the middle of a drain
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("rstmid_t1_busy", {31'd0, busy}, 32'd1);
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_cnt", cnt, 32'd0);
    chk_ctrl("rstmid_ctrl", 5'b00000, 5'b00000);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid_nodone%0d", k), {31'd0, done}, 32'd0);
      chk($sformatf("rstmid_idle%0d", k), {31'd0, busy}, 32'd0);
      cyc();
    end

    // Counter saturation on the 4-bit instance
    load_use = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (k == 14) chk("sat_reach", {28'd0, cnt_s}, 32'd15);
    end
    @(negedge clk);
    chk("sat_hold", {28'd0, cnt_s}, 32'd15);
    chk("nosat_wide", cnt, 32'd20);
    load_use = 1'b0;

    // Flush accepted from IDLE during a memory stall
    cyc();
    flush = 1'b1; mem_read = 1'b1;
    @(negedge clk);
    chk_ctrl("flush_memstall", 5'b01111, 5'b01000);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_memstall_busy", {31'd0, busy}, 32'd1);
    mem_read = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
